// File: rtl/cci_mpf_fiu_resp_model_pkg.sv
// Shared request payload types, arbiter priority states and line-index helper
// for the FIU responder model.
package cci_mpf_fiu_resp_model_pkg;

  localparam int LINE_ADDR_W = 42;
  localparam int MEM_IDX_W   = 8;
  localparam int MDATA_W     = 16;
  localparam int DATA_W      = 512;

  typedef struct packed {
    logic [LINE_ADDR_W-1:0] addr;
    logic [MDATA_W-1:0]     mdata;
  } t_rd_req;

  typedef struct packed {
    logic [LINE_ADDR_W-1:0] addr;
    logic [MDATA_W-1:0]     mdata;
    logic [DATA_W-1:0]      data;
  } t_wr_req;

  typedef enum logic {
    PRI_RD = 1'b0,
    PRI_WR = 1'b1
  } t_arb_pri;

  // Upper address bits are dropped on purpose: lines alias modulo the model size.
  function automatic logic [MEM_IDX_W-1:0] line_idx(input logic [LINE_ADDR_W-1:0] addr);
    return addr[MEM_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/cci_mpf_fiu_resp_fifo.sv
// Request FIFO: push at edge, head visible next cycle; registered almfull from count.
// No backpressure port: a push into a full FIFO without a pop is dropped and flagged.
module cci_mpf_fiu_resp_fifo #(
  parameter type T      = logic,
  parameter int  DEPTH  = 16,
  parameter int  THRESH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  T     push_dat,
  input  logic pop,
  output logic head_valid,
  output T     head,
  output logic almfull,
  output logic overflow
);

  localparam int AW = $clog2(DEPTH);

  T               r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic           r_almfull;
  logic           w_full;
  logic           w_pop;
  logic           w_push;

  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_pop      = pop && (r_count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push     = push && (!w_full || w_pop);
  assign overflow   = push && w_full && !w_pop;
  assign head_valid = (r_count != '0);
  assign head       = r_mem[r_rptr];
  assign almfull    = r_almfull;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_almfull <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count   <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_almfull <= (r_count >= (AW+1)'(DEPTH - THRESH));
    end
  end

endmodule

// File: rtl/cci_mpf_fiu_resp_model.sv
// FIU-side responder: c0 reads / c1 writes into a line memory; write rsp 2 cycles, read rsp RD_LATENCY.
// Requests are valid-only; almfull is the only backpressure, responses are never stalled.
module cci_mpf_fiu_resp_model
  import cci_mpf_fiu_resp_model_pkg::*;
#(
  parameter int LINE_ADDR_WIDTH = LINE_ADDR_W,
  parameter int MEM_IDX_WIDTH   = MEM_IDX_W,
  parameter int MDATA_WIDTH     = MDATA_W,
  parameter int DATA_WIDTH      = DATA_W,
  parameter int RD_LATENCY      = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int ALMFULL_THRESH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       c0_req_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] c0_req_addr,
  input  logic [MDATA_WIDTH-1:0]     c0_req_mdata,
  input  logic                       c1_req_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] c1_req_addr,
  input  logic [MDATA_WIDTH-1:0]     c1_req_mdata,
  input  logic [DATA_WIDTH-1:0]      c1_req_data,
  output logic                       c0_almfull,
  output logic                       c1_almfull,
  output logic                       c0_rsp_valid,
  output logic [MDATA_WIDTH-1:0]     c0_rsp_mdata,
  output logic [DATA_WIDTH-1:0]      c0_rsp_data,
  output logic                       c1_rsp_valid,
  output logic [MDATA_WIDTH-1:0]     c1_rsp_mdata,
  output logic                       err_overflow
);

  localparam int N_LINES = 2**MEM_IDX_WIDTH;
  localparam int PIPE_N  = RD_LATENCY - 1;

  t_rd_req  w_rd_push;
  t_rd_req  w_rd_head;
  t_wr_req  w_wr_push;
  t_wr_req  w_wr_head;
  logic     w_rd_head_vld;
  logic     w_wr_head_vld;
  logic     w_rd_ovf;
  logic     w_wr_ovf;
  logic     w_gnt_rd;
  logic     w_gnt_wr;
  t_arb_pri r_pri;
  t_arb_pri w_pri_nxt;

  assign w_rd_push = '{addr: c0_req_addr, mdata: c0_req_mdata};
  assign w_wr_push = '{addr: c1_req_addr, mdata: c1_req_mdata, data: c1_req_data};

  cci_mpf_fiu_resp_fifo #(.T(t_rd_req), .DEPTH(FIFO_DEPTH), .THRESH(ALMFULL_THRESH)) u_rd_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (c0_req_valid),
    .push_dat   (w_rd_push),
    .pop        (w_gnt_rd),
    .head_valid (w_rd_head_vld),
    .head       (w_rd_head),
    .almfull    (c0_almfull),
    .overflow   (w_rd_ovf)
  );

  cci_mpf_fiu_resp_fifo #(.T(t_wr_req), .DEPTH(FIFO_DEPTH), .THRESH(ALMFULL_THRESH)) u_wr_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (c1_req_valid),
    .push_dat   (w_wr_push),
    .pop        (w_gnt_wr),
    .head_valid (w_wr_head_vld),
    .head       (w_wr_head),
    .almfull    (c1_almfull),
    .overflow   (w_wr_ovf)
  );

  // Priority only rotates when both heads compete for the single memory port.
  always_comb begin
    w_gnt_rd  = 1'b0;
    w_gnt_wr  = 1'b0;
    w_pri_nxt = r_pri;
    if (w_rd_head_vld && w_wr_head_vld) begin
      if (r_pri == PRI_RD) begin
        w_gnt_rd  = 1'b1;
        w_pri_nxt = PRI_WR;
      end else begin
        w_gnt_wr  = 1'b1;
        w_pri_nxt = PRI_RD;
      end
    end else begin
      w_gnt_rd = w_rd_head_vld;
      w_gnt_wr = w_wr_head_vld;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_pri <= PRI_RD;
    else          r_pri <= w_pri_nxt;
  end

  logic [DATA_WIDTH-1:0]    r_mem [N_LINES];
  logic [N_LINES-1:0]       r_line_vld;
  logic [MEM_IDX_WIDTH-1:0] w_rd_idx;
  logic [MEM_IDX_WIDTH-1:0] w_wr_idx;
  logic                     r_c1_rsp_vld;
  logic [MDATA_WIDTH-1:0]   r_c1_rsp_mdata;
  logic                     r_err;

  assign w_rd_idx = line_idx(w_rd_head.addr);
  assign w_wr_idx = line_idx(w_wr_head.addr);

  always_ff @(posedge clk) begin
    if (w_gnt_wr) begin
      r_mem[w_wr_idx] <= w_wr_head.data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_line_vld     <= '0;
      r_c1_rsp_vld   <= 1'b0;
      r_c1_rsp_mdata <= '0;
      r_err          <= 1'b0;
    end else begin
      if (w_gnt_wr) r_line_vld[w_wr_idx] <= 1'b1;
      r_c1_rsp_vld   <= w_gnt_wr;
      r_c1_rsp_mdata <= w_gnt_wr ? w_wr_head.mdata : '0;
      r_err          <= r_err | w_rd_ovf | w_wr_ovf;
    end
  end

  // Stage 0 is the registered RAM read; the rest pad out to RD_LATENCY.
  logic [PIPE_N-1:0]      r_rd_vld;
  logic [MDATA_WIDTH-1:0] r_rd_mdata [PIPE_N];
  logic [DATA_WIDTH-1:0]  r_rd_data  [PIPE_N];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_vld <= '0;
      for (int i = 0; i < PIPE_N; i++) begin
        r_rd_mdata[i] <= '0;
        r_rd_data[i]  <= '0;
      end
    end else begin
      r_rd_vld <= {r_rd_vld[PIPE_N-2:0], w_gnt_rd};
      if (w_gnt_rd) begin
        r_rd_mdata[0] <= w_rd_head.mdata;
        r_rd_data[0]  <= r_line_vld[w_rd_idx] ? r_mem[w_rd_idx] : '0;
      end
      for (int i = 1; i < PIPE_N; i++) begin
        r_rd_mdata[i] <= r_rd_mdata[i-1];
        r_rd_data[i]  <= r_rd_data[i-1];
      end
    end
  end

  assign c0_rsp_valid = r_rd_vld[PIPE_N-1];
  assign c0_rsp_mdata = r_rd_mdata[PIPE_N-1];
  assign c0_rsp_data  = r_rd_data[PIPE_N-1];
  assign c1_rsp_valid = r_c1_rsp_vld;
  assign c1_rsp_mdata = r_c1_rsp_mdata;
  assign err_overflow = r_err;

endmodule

// File: tb/tb_cci_mpf_fiu_resp_model.sv
// Bench for the FIU responder model: directed vectors, contention, overflow and reset
// sequences, with a scoreboard of expected responses and a FIFO occupancy model.
module tb_cci_mpf_fiu_resp_model;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         c0_req_valid;
  logic [41:0]  c0_req_addr;
  logic [15:0]  c0_req_mdata;
  logic         c1_req_valid;
  logic [41:0]  c1_req_addr;
  logic [15:0]  c1_req_mdata;
  logic [511:0] c1_req_data;
  logic         c0_almfull;
  logic         c1_almfull;
  logic         c0_rsp_valid;
  logic [15:0]  c0_rsp_mdata;
  logic [511:0] c0_rsp_data;
  logic         c1_rsp_valid;
  logic [15:0]  c1_rsp_mdata;
  logic         err_overflow;

  always #5 clk = ~clk;

  cci_mpf_fiu_resp_model dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .c0_req_valid (c0_req_valid),
    .c0_req_addr  (c0_req_addr),
    .c0_req_mdata (c0_req_mdata),
    .c1_req_valid (c1_req_valid),
    .c1_req_addr  (c1_req_addr),
    .c1_req_mdata (c1_req_mdata),
    .c1_req_data  (c1_req_data),
    .c0_almfull   (c0_almfull),
    .c1_almfull   (c1_almfull),
    .c0_rsp_valid (c0_rsp_valid),
    .c0_rsp_mdata (c0_rsp_mdata),
    .c0_rsp_data  (c0_rsp_data),
    .c1_rsp_valid (c1_rsp_valid),
    .c1_rsp_mdata (c1_rsp_mdata),
    .err_overflow (err_overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] dpat(input logic [31:0] w);
    return {16{w}};
  endfunction

  // Scoreboard: entries pushed when the FIFO accepts a request, due = -1 skips timing.
  typedef struct {
    logic [15:0]  mdata;
    logic [511:0] data;
    int           due;
  } sb_t;

  sb_t          q0[$];
  sb_t          q1[$];
  logic [511:0] d0_data = '0;
  int           d0_lat  = -1;
  int           d1_lat  = -1;

  // Occupancy model: one memory op per cycle, rotating priority only under contention.
  logic [4:0] m_cnt0, m_cnt1;
  logic       m_pri_wr, m_alm0, m_alm1, m_ovf;
  logic       m_g_rd, m_acc0, m_acc1;

  always_comb begin
    m_g_rd = 1'b0;
    m_acc0 = 1'b0;
    m_acc1 = 1'b0;
    m_g_rd = (m_cnt0 != 0) && ((m_cnt1 == 0) || !m_pri_wr);
    m_acc0 = c0_req_valid && ((m_cnt0 != 5'd16) || m_g_rd);
    m_acc1 = c1_req_valid && ((m_cnt1 != 5'd16) || (!m_g_rd && m_cnt1 != 0));
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt0   <= '0;
      m_cnt1   <= '0;
      m_pri_wr <= 1'b0;
      m_alm0   <= 1'b0;
      m_alm1   <= 1'b0;
      m_ovf    <= 1'b0;
    end else begin
      m_cnt0   <= m_cnt0 + 5'(m_acc0) - 5'(m_g_rd);
      m_cnt1   <= m_cnt1 + 5'(m_acc1) - 5'(!m_g_rd && m_cnt1 != 0);
      if (m_cnt0 != 0 && m_cnt1 != 0) m_pri_wr <= ~m_pri_wr;
      m_alm0   <= (m_cnt0 >= 5'd12);
      m_alm1   <= (m_cnt1 >= 5'd12);
      m_ovf    <= m_ovf | (c0_req_valid && !m_acc0) | (c1_req_valid && !m_acc1);
      if (m_acc0) q0.push_back('{mdata: c0_req_mdata, data: d0_data, due: (d0_lat < 0) ? -1 : cyc + d0_lat});
      if (m_acc1) q1.push_back('{mdata: c1_req_mdata, data: '0, due: (d1_lat < 0) ? -1 : cyc + d1_lat});
    end
  end

  logic seen_alm0 = 1'b0;
  logic seen_alm1 = 1'b0;

  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (c0_rsp_valid) begin
        if (q0.size() == 0) begin
          chk("c0_spurious_rsp_valid", c0_rsp_valid, 1'b0);
        end else begin
          e = q0.pop_front();
          chk("c0_rsp_mdata", c0_rsp_mdata, e.mdata);
          chk("c0_rsp_data", c0_rsp_data, e.data);
          if (e.due >= 0) chk("c0_rsp_cycle", cyc, e.due);
        end
      end
      if (c1_rsp_valid) begin
        if (q1.size() == 0) begin
          chk("c1_spurious_rsp_valid", c1_rsp_valid, 1'b0);
        end else begin
          e = q1.pop_front();
          chk("c1_rsp_mdata", c1_rsp_mdata, e.mdata);
          if (e.due >= 0) chk("c1_rsp_cycle", cyc, e.due);
        end
      end
      chk("c0_almfull", c0_almfull, m_alm0);
      chk("c1_almfull", c1_almfull, m_alm1);
      chk("err_overflow", err_overflow, m_ovf);
      if (c0_almfull) seen_alm0 = 1'b1;
      if (c1_almfull) seen_alm1 = 1'b1;
    end
  end

  typedef struct {
    logic         is_wr;
    logic [41:0]  addr;
    logic [15:0]  mdata;
    logic [511:0] data;
    int           lat;
  } vec_t;

  vec_t vecs[7];

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_req();
    c0_req_valid = 1'b0;
    c1_req_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    for (int k = 0; k < budget && (q0.size() != 0 || q1.size() != 0); k++) @(negedge clk);
    chk(name, q0.size() + q1.size(), 0);
  endtask

  task automatic chk_outputs_zero();
    chk("rst_c0_rsp_valid", c0_rsp_valid, 1'b0);
    chk("rst_c1_rsp_valid", c1_rsp_valid, 1'b0);
    chk("rst_c0_rsp_mdata", c0_rsp_mdata, '0);
    chk("rst_c0_rsp_data",  c0_rsp_data, '0);
    chk("rst_c1_rsp_mdata", c1_rsp_mdata, '0);
    chk("rst_c0_almfull",   c0_almfull, 1'b0);
    chk("rst_c1_almfull",   c1_almfull, 1'b0);
    chk("rst_err_overflow", err_overflow, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 42'h005,         16'h0011, dpat(32'hA5A5A5A5), 2};
    vecs[1] = '{1'b0, 42'h005,         16'h0022, dpat(32'hA5A5A5A5), 8};
    vecs[2] = '{1'b0, 42'h07F,         16'h0033, '0,                 8};
    vecs[3] = '{1'b1, 42'h105,         16'h0044, 512'hBEEF,          2};
    vecs[4] = '{1'b0, 42'h005,         16'h0055, 512'hBEEF,          8};
    vecs[5] = '{1'b1, 42'h3FF00000205, 16'h0066, dpat(32'h12345678), 2};
    vecs[6] = '{1'b0, 42'h205,         16'h0077, dpat(32'h12345678), 8};

    reset_n      = 1'b0;
    c0_req_valid = 1'b0;
    c0_req_addr  = '0;
    c0_req_mdata = '0;
    c1_req_valid = 1'b0;
    c1_req_addr  = '0;
    c1_req_mdata = '0;
    c1_req_data  = '0;
    idle(3);
    chk_outputs_zero();
    reset_n = 1'b1;
    idle(2);

    // Isolated transactions: latency, cold-line zero data, address aliasing.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].is_wr) begin
        c1_req_valid = 1'b1;
        c1_req_addr  = vecs[i].addr;
        c1_req_mdata = vecs[i].mdata;
        c1_req_data  = vecs[i].data;
        d1_lat       = vecs[i].lat;
      end else begin
        c0_req_valid = 1'b1;
        c0_req_addr  = vecs[i].addr;
        c0_req_mdata = vecs[i].mdata;
        d0_data      = vecs[i].data;
        d0_lat       = vecs[i].lat;
      end
      @(negedge clk);
      clear_req();
      idle(12);
      chk("vec_drained", q0.size() + q1.size(), 0);
    end

    // Simultaneous read/write for 4 cycles: grants RD,WR,RD,WR; each read hits the
    // line written by the previous write, which is granted first.
    for (int i = 0; i < 4; i++) begin
      c0_req_valid = 1'b1;
      c0_req_addr  = 42'h00F + 42'(i);
      c0_req_mdata = 16'h0300 + 16'(i);
      d0_data      = (i == 0) ? '0 : dpat(32'hC0DE0000 | 32'(i - 1));
      d0_lat       = 8 + i;
      c1_req_valid = 1'b1;
      c1_req_addr  = 42'h010 + 42'(i);
      c1_req_mdata = 16'h0400 + 16'(i);
      c1_req_data  = dpat(32'hC0DE0000 | 32'(i));
      d1_lat       = 3 + i;
      @(negedge clk);
    end
    clear_req();
    drain("contention_drained", 40);

    // Saturating burst on both channels: fills both FIFOs and overflows.
    d0_data = '0;
    d0_lat  = -1;
    d1_lat  = -1;
    for (int i = 0; i < 40; i++) begin
      c0_req_valid = 1'b1;
      c0_req_addr  = 42'h080 + 42'(i);
      c0_req_mdata = 16'h1000 + 16'(i);
      c1_req_valid = 1'b1;
      c1_req_addr  = 42'h0C0 + 42'(i);
      c1_req_mdata = 16'h2000 + 16'(i);
      c1_req_data  = dpat(32'h5A000000 | 32'(i));
      @(negedge clk);
    end
    clear_req();
    drain("burst_drained", 400);
    chk("burst_seen_c0_almfull", seen_alm0, 1'b1);
    chk("burst_seen_c1_almfull", seen_alm1, 1'b1);
    chk("burst_err_overflow", err_overflow, 1'b1);

    // Reset with three reads in flight: everything clears, nothing stale afterwards.
    d0_data = dpat(32'h12345678);
    d0_lat  = 8;
    for (int i = 0; i < 3; i++) begin
      c0_req_valid = 1'b1;
      c0_req_addr  = 42'h005;
      c0_req_mdata = 16'h0500 + 16'(i);
      @(negedge clk);
    end
    clear_req();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk_outputs_zero();
    idle(2);
    reset_n = 1'b1;
    idle(15);
    chk("post_reset_quiet", q0.size() + q1.size(), 0);

    c0_req_valid = 1'b1;
    c0_req_addr  = 42'h005;
    c0_req_mdata = 16'h0600;
    d0_data      = '0;
    d0_lat       = 8;
    @(negedge clk);
    clear_req();
    drain("post_reset_read_drained", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
